psa_seq_ctrl: RTL and testbench
===============================

PSA_SEQ_CTRL -- requirements
Module: psa_seq_ctrl

Interface
REQ-001 SHALL provide parameter: ERR_CLR_PRIO, 0, priority when err_clr and a sticky-set coincide (0 = set wins, 1 = clear wins).
REQ-002 SHALL provide port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: in_valid  input  1  operand pair valid.
REQ-005 SHALL provide port: in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port: a  input  16  operand A, four signed 4-bit lanes.
REQ-007 SHALL provide port: b  input  16  operand B, four signed 4-bit lanes.
REQ-008 SHALL provide port: out_valid  output  1  result valid.
REQ-009 SHALL provide port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port: sum  output  16  per-lane result.
REQ-011 SHALL provide port: error  output  1  at least one lane overflowed in the current result.
REQ-012 SHALL provide port: err_sticky  output  1  accumulated error since reset or last clear.
REQ-013 SHALL provide port: err_clr  input  1  clear err_sticky.
REQ-014 SHALL provide port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE).
REQ-016 SHALL accept operands on a rising edge with in_valid & in_ready, registering a and b and entering CALC with lane index 0; sum and error SHALL clear to 0 on accept.
REQ-017 SHALL compute exactly one 4-bit lane per CALC cycle using one shared 4-bit adder, lane 0 (bits 3:0) first through lane 3; carry-in SHALL be 0 and carries SHALL NOT propagate between lanes.
REQ-018 SHALL flag lane overflow when both operand lane MSBs are equal and the result MSB differs; error SHALL be the OR of all lane flags.
REQ-019 SHALL write the lane-3 result on the 4th CALC edge and enter DONE; out_valid SHALL be high from the accept edge plus 5 cycles.
REQ-020 SHALL hold out_valid, sum and error stable in DONE until out_ready is sampled high; then SHALL return to IDLE. DONE SHALL last at least one cycle even if out_ready was already high.
REQ-021 SHALL ignore in_valid outside IDLE; operands SHALL NOT be sampled when a or b change mid-CALC. Sustained throughput is one result per 6 cycles.
REQ-022 SHALL set err_sticky on the DONE-entry edge when the completed error is 1; SHALL clear it on any edge with err_clr=1; on coincidence, ERR_CLR_PRIO SHALL decide.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-CALC or DONE, asynchronously force state IDLE, lane index 0, in_ready 1, out_valid 0, busy 0, sum 16'h0000, error 0, err_sticky 0, and discard any in-flight operation.
REQ-024 SHALL resume accepting operands on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL honour macro PSA_SAT_EN: when defined, an overflowed lane SHALL saturate to 4'h7 on positive overflow or 4'h8 on negative overflow; when undefined, the lane SHALL wrap (modulo 16). The error flag behaviour SHALL be identical in both builds.

Verification
REQ-026 SHALL cover: a=16'h1234, b=16'h1111 -> sum 16'h2345, error 0, out_valid exactly 5 cycles after accept.
REQ-027 SHALL cover: a=16'h7000, b=16'h1000 -> error 1, err_sticky 1; sum 16'h8000 without PSA_SAT_EN, 16'h7000 with it.
REQ-028 SHALL cover: a=16'h0088, b=16'h0088 -> error 1; sum 16'h0000 without PSA_SAT_EN, 16'h0088 with it.
REQ-029 SHALL cover: out_ready held low 3 cycles in DONE with in_valid high and a/b changing -> sum/error stable, in_ready 0; after out_ready, the next accept takes the then-current a/b.
REQ-030 SHALL cover: rst_n pulsed low after 2 CALC cycles -> all outputs at reset values immediately; new a=16'h0001, b=16'h0001 yields sum 16'h0002.
REQ-031 SHALL cover: err_clr high on the same edge an overflowing result enters DONE -> err_sticky 1 with ERR_CLR_PRIO=0, 0 with ERR_CLR_PRIO=1.

Source files
------------

// File: rtl/psa_seq_ctrl.sv
// Packed-lane adder sequencer: four signed 4-bit lanes summed one per cycle on a shared adder.
// Build option PSA_SAT_EN: overflowed lanes saturate (7/8) instead of wrapping.
module psa_seq_ctrl #(
   parameter bit ERR_CLR_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum,
   output logic        error,
   output logic        err_sticky,
   input  logic        err_clr,
   output logic        busy
);

   // state | meaning
   // IDLE  | waiting for an operand pair
   // CALC  | one lane per cycle, lane 0 first
   // DONE  | result held until out_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  lane;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [3:0]  lane_a;
   logic [3:0]  lane_b;
   logic [3:0]  lane_raw;
   logic [3:0]  lane_res;
   logic        lane_ovf;
   logic        err_next;
   logic        sticky_set;

   always_comb begin
      lane_a   = a_reg[{lane, 2'b00} +: 4];
      lane_b   = b_reg[{lane, 2'b00} +: 4];
      lane_raw = lane_a + lane_b;
      lane_ovf = (lane_a[3] == lane_b[3]) && (lane_raw[3] != lane_a[3]);
`ifdef PSA_SAT_EN
      lane_res = lane_ovf ? (lane_a[3] ? 4'h8 : 4'h7) : lane_raw;
`else
      lane_res = lane_raw;
`endif
      err_next   = error | lane_ovf;
      sticky_set = (state == CALC) && (lane == 2'd3) && err_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lane       <= 2'd0;
         a_reg      <= 16'h0000;
         b_reg      <= 16'h0000;
         sum        <= 16'h0000;
         error      <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  lane  <= 2'd0;
                  sum   <= 16'h0000;
                  error <= 1'b0;
                  state <= CALC;
               end
            end
            CALC: begin
               sum[{lane, 2'b00} +: 4] <= lane_res;
               error <= err_next;
               lane  <= lane + 2'd1;
               if (lane == 2'd3) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // ERR_CLR_PRIO decides only when a clear and a DONE-entry set coincide
         if (err_clr && (ERR_CLR_PRIO || !sticky_set)) err_sticky <= 1'b0;
         else if (sticky_set)                          err_sticky <= 1'b1;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_psa_seq_ctrl.sv
// Self-checking bench for psa_seq_ctrl: vector table, random vectors against a lane model,
// and hand sequences for back-pressure, mid-CALC reset and clear/set coincidence.
module tb_psa_seq_ctrl;

   typedef struct {
      logic [15:0] sum;
      logic        err;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum_wrap;
      logic [15:0] sum_sat;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        out_ready = 1'b0;
   logic        err_clr = 1'b0;

   logic        in_ready0, out_valid0, error0, err_sticky0, busy0;
   logic        in_ready1, out_valid1, error1, err_sticky1, busy1;
   logic [15:0] sum0, sum1;

   int   errors = 0;
   int   checks = 0;
   logic s0_exp = 1'b0;
   logic s1_exp = 1'b0;
   exp_t sb[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   psa_seq_ctrl #(.ERR_CLR_PRIO(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
      .sum(sum0), .error(error0), .err_sticky(err_sticky0), .err_clr(err_clr), .busy(busy0)
   );

   psa_seq_ctrl #(.ERR_CLR_PRIO(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
      .sum(sum1), .error(error1), .err_sticky(err_sticky1), .err_clr(err_clr), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pick(input logic [15:0] wrap, input logic [15:0] sat);
`ifdef PSA_SAT_EN
      return sat;
`else
      return wrap;
`endif
   endfunction

   // Lane model in signed integer arithmetic
   function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb);
      exp_t r;
      r.sum = 16'h0;
      r.err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         int la, lb, s;
         logic [3:0] wrap, sat;
         la = int'($signed(va[i*4 +: 4]));
         lb = int'($signed(vb[i*4 +: 4]));
         s  = la + lb;
         wrap = 4'(s);
         sat  = wrap;
         if (s > 7 || s < -8) begin
            r.err = 1'b1;
            sat   = (s > 7) ? 4'h7 : 4'h8;
         end
         r.sum[i*4 +: 4] = pick({12'h0, wrap}, {12'h0, sat}) [3:0];
      end
      return r;
   endfunction

   task automatic accept_txn(input logic [15:0] va, input logic [15:0] vb, input exp_t e);
      check("idle_in_ready", in_ready0, 1);
      in_valid = 1'b1;
      a = va;
      b = vb;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Latency counts the accept edge as edge 1; out_valid must follow the 5th edge.
   task automatic wait_result(input string name, output exp_t got);
      int   cnt;
      exp_t e;
      cnt = 1;
      while (!out_valid0 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({name, "_latency"}, cnt, 5);
      e.sum = 16'h0;
      e.err = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_scoreboard: got empty queue required one entry", name);
      end else begin
         e = sb.pop_front();
         check({name, "_sum"}, sum0, e.sum);
         check({name, "_error"}, error0, e.err);
         check({name, "_sum_prio1"}, sum1, e.sum);
         s0_exp = s0_exp | e.err;
         s1_exp = s1_exp | e.err;
         check({name, "_sticky"}, err_sticky0, s0_exp);
         check({name, "_sticky_prio1"}, err_sticky1, s1_exp);
      end
      got = e;
   endtask

   task automatic release_done(input string name, input exp_t e, input int hold);
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_valid"}, out_valid0, 1);
         check({name, "_hold_sum"}, sum0, e.sum);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_back_idle"}, in_ready0, 1);
   endtask

   task automatic clear_sticky();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      s0_exp = 1'b0;
      s1_exp = 1'b0;
   endtask

   initial begin
      exp_t e, got;
      vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 16'h2345, 1'b0};
      vecs[1] = '{16'h7000, 16'h1000, 16'h8000, 16'h7000, 1'b1};
      vecs[2] = '{16'h0088, 16'h0088, 16'h0000, 16'h0088, 1'b1};
      vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFF0, 16'hFFF0, 1'b0};
      vecs[4] = '{16'h8888, 16'hFFFF, 16'h7777, 16'h8888, 1'b1};
      vecs[5] = '{16'h0007, 16'h0001, 16'h0008, 16'h0007, 1'b1};
      vecs[6] = '{16'h4321, 16'h3456, 16'h7777, 16'h7777, 1'b0};

      #12;
      check("rst_in_ready", in_ready0, 1);
      check("rst_out_valid", out_valid0, 0);
      check("rst_busy", busy0, 0);
      check("rst_sum", sum0, 16'h0);
      check("rst_error", error0, 0);
      check("rst_sticky", err_sticky0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors; out_ready held high on even entries so DONE must still last a cycle
      for (int i = 0; i < 7; i++) begin
         e.sum = pick(vecs[i].sum_wrap, vecs[i].sum_sat);
         e.err = vecs[i].err;
         out_ready = (i % 2 == 0);
         accept_txn(vecs[i].a, vecs[i].b, e);
         check("calc_busy", busy0, 1);
         check("calc_no_valid", out_valid0, 0);
         wait_result($sformatf("vec%0d", i), got);
         release_done($sformatf("vec%0d", i), got, i % 3);
         clear_sticky();
         check("sticky_cleared", err_sticky0, 0);
      end

      for (int i = 0; i < 6; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         accept_txn(ra, rb, model(ra, rb));
         wait_result($sformatf("rnd%0d", i), got);
         release_done($sformatf("rnd%0d", i), got, int'($urandom_range(0, 2)));
      end

      // Back-pressure with in_valid high and operands changing in DONE
      clear_sticky();
      e.sum = pick(16'h0008, 16'h0007);
      e.err = 1'b1;
      accept_txn(16'h0007, 16'h0001, e);
      wait_result("bp", got);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         @(posedge clk); #1;
         check("bp_sum_stable", sum0, got.sum);
         check("bp_err_stable", error0, got.err);
         check("bp_in_ready", in_ready0, 0);
      end
      a = 16'h1111;
      b = 16'h2222;
      out_ready = 1'b1;
      e.sum = 16'h3333;
      e.err = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result("bp_next", got);
      release_done("bp_next", got, 0);

      // Reset two CALC cycles into an operation, with sticky set beforehand
      check("pre_rst_sticky", err_sticky0, 1);
      e.sum = 16'h2345;
      e.err = 1'b0;
      accept_txn(16'h1234, 16'h1111, e);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midcalc_busy", busy0, 1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      s0_exp = 1'b0;
      s1_exp = 1'b0;
      check("async_in_ready", in_ready0, 1);
      check("async_out_valid", out_valid0, 0);
      check("async_busy", busy0, 0);
      check("async_sum", sum0, 16'h0);
      check("async_error", error0, 0);
      check("async_sticky", err_sticky0, 0);
      #3;
      rst_n = 1'b1;
      e.sum = 16'h0002;
      e.err = 1'b0;
      accept_txn(16'h0001, 16'h0001, e);
      wait_result("post_rst", got);
      release_done("post_rst", got, 0);

      // err_clr on the DONE-entry edge of an overflowing result
      clear_sticky();
      e.sum = pick(16'h8000, 16'h7000);
      e.err = 1'b1;
      accept_txn(16'h7000, 16'h1000, e);
      repeat (3) begin
         @(posedge clk); #1;
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("coin_valid", out_valid0, 1);
      check("coin_sticky_prio0", err_sticky0, 1);
      check("coin_sticky_prio1", err_sticky1, 0);
      if (sb.size() != 0) begin
         got = sb.pop_front();
         check("coin_sum", sum0, got.sum);
         check("coin_error", error0, got.err);
      end
      release_done("coin", got, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
